// File: rtl/mux_nx1_pipe.sv
// rtl/mux_nx1_pipe.sv - N:1 channel selector with registered output and 2-entry skid buffer
module mux_nx1_pipe #(
  parameter int WIDTH = 2,
  parameter int N_IN  = 8,
  parameter int SEL_W = 3
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic [N_IN*WIDTH-1:0] iX,
  input  logic [SEL_W-1:0]      iSel,
  input  logic                  iMode,
  input  logic                  iValid,
  output logic                  oReady,
  output logic [WIDTH-1:0]      oX,
  output logic [SEL_W-1:0]      oSel,
  output logic                  oSelErr,
  output logic                  oValid,
  input  logic                  iReady
);

  logic [WIDTH-1:0] skid_x;
  logic [SEL_W-1:0] skid_sel;
  logic             skid_err;
  logic             skid_v;
  logic [SEL_W-1:0] cnt;

  logic             acc;
  logic             xfer;
  logic [SEL_W-1:0] es;
  logic [WIDTH-1:0] new_x;
  logic             new_err;

  // Ready depends only on registered state and reset, so upstream sees no combinational loop.
  assign oReady = ~skid_v & ~iRst;
  assign acc    = iValid & oReady;
  assign xfer   = oValid & iReady;
  assign es     = iMode ? cnt : iSel;

  // Out-of-range selects fall through the loop untouched: zero data, error flagged.
  always_comb begin
    new_x   = '0;
    new_err = 1'b1;
    for (int k = 0; k < N_IN; k++) begin
      if (es == SEL_W'(k)) begin
        new_x   = iX[k*WIDTH +: WIDTH];
        new_err = 1'b0;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      oValid   <= 1'b0;
      oX       <= '0;
      oSel     <= '0;
      oSelErr  <= 1'b0;
      skid_v   <= 1'b0;
      skid_x   <= '0;
      skid_sel <= '0;
      skid_err <= 1'b0;
    end else if (!oValid || xfer) begin
      if (skid_v) begin
        oX      <= skid_x;
        oSel    <= skid_sel;
        oSelErr <= skid_err;
        oValid  <= 1'b1;
        skid_v  <= 1'b0;
      end else if (acc) begin
        oX      <= new_x;
        oSel    <= es;
        oSelErr <= new_err;
        oValid  <= 1'b1;
      end else begin
        oValid  <= 1'b0;
      end
    end else if (acc) begin
      skid_x   <= new_x;
      skid_sel <= es;
      skid_err <= new_err;
      skid_v   <= 1'b1;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      cnt <= '0;
    end else if (acc && iMode) begin
      cnt <= (cnt == SEL_W'(N_IN - 1)) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// tb/tb_mux_nx1_pipe.sv - self-checking bench for mux_nx1_pipe
module tb_mux_nx1_pipe;

  localparam int W8 = 4;
  localparam int N8 = 8;
  localparam int W5 = 4;
  localparam int N5 = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [N8*W8-1:0] x8;
  logic [2:0]      sel8;
  logic            mode8, valid8, ready8;
  logic            o_ready8, o_valid8, o_err8;
  logic [W8-1:0]   o_x8;
  logic [2:0]      o_sel8;

  logic [N5*W5-1:0] x5;
  logic [2:0]      sel5;
  logic            valid5;
  logic            o_ready5, o_valid5, o_err5;
  logic [W5-1:0]   o_x5;
  logic [2:0]      o_sel5;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mux_nx1_pipe #(.WIDTH(W8), .N_IN(N8), .SEL_W(3)) u8 (
    .iClk(clk), .iRst(rst), .iX(x8), .iSel(sel8), .iMode(mode8), .iValid(valid8),
    .oReady(o_ready8), .oX(o_x8), .oSel(o_sel8), .oSelErr(o_err8), .oValid(o_valid8),
    .iReady(ready8)
  );

  mux_nx1_pipe #(.WIDTH(W5), .N_IN(N5), .SEL_W(3)) u5 (
    .iClk(clk), .iRst(rst), .iX(x5), .iSel(sel5), .iMode(1'b0), .iValid(valid5),
    .oReady(o_ready5), .oX(o_x5), .oSel(o_sel5), .oSelErr(o_err5), .oValid(o_valid5),
    .iReady(1'b1)
  );

  // Reference: an ordered list of accepted beats with room for two, plus a scan index.
  typedef struct {
    logic [W8-1:0] x;
    logic [2:0]    sel;
    logic          err;
  } beat_t;

  beat_t q[$];
  int    scan = 0;

  always @(posedge clk) begin
    int    es;
    bit    take;
    bit    give;
    beat_t b;
    if (rst) begin
      q.delete();
      scan = 0;
    end else begin
      take = valid8 && (q.size() < 2);
      give = (q.size() > 0) && ready8;
      es   = mode8 ? scan : int'(sel8);
      if (give) void'(q.pop_front());
      if (take) begin
        b.sel = 3'(es);
        b.err = (es >= N8);
        b.x   = b.err ? '0 : W8'((x8 >> (es * W8)) & ((1 << W8) - 1));
        q.push_back(b);
        if (mode8) scan = (scan + 1) % N8;
      end
    end
  end

  function automatic logic [N8*W8-1:0] ident8();
    logic [N8*W8-1:0] v;
    for (int k = 0; k < N8; k++) v[k*W8 +: W8] = W8'(k);
    return v;
  endfunction

  task automatic idle8();
    valid8 = 1'b0; ready8 = 1'b1; mode8 = 1'b0; sel8 = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    x8 = ident8(); valid8 = 1'b1; ready8 = 1'b1; mode8 = 1'b0; sel8 = 3'd3;
    x5 = '0; sel5 = '0; valid5 = 1'b1;
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++; if (o_valid8 !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", o_valid8); end
      n_checks++; if (o_ready8 !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", o_ready8); end
      n_checks++; if (o_x8 !== '0) begin n_fail++; $display("FAIL reset_x got %0h want 0", o_x8); end
      n_checks++; if (o_sel8 !== '0) begin n_fail++; $display("FAIL reset_sel got %0d want 0", o_sel8); end
    end
    rst = 1'b0; valid8 = 1'b0; valid5 = 1'b0;
    #1;
    n_checks++; if (o_ready8 !== 1'b1) begin n_fail++; $display("FAIL release_ready got %b want 1", o_ready8); end
    @(negedge clk);
    n_checks++; if (o_valid8 !== 1'b0) begin n_fail++; $display("FAIL release_valid got %b want 0", o_valid8); end
  endtask

  task automatic test_explicit();
    x8 = ident8(); ready8 = 1'b1; mode8 = 1'b0;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_checks++;
        if (o_valid8 !== 1'b1 || o_x8 !== W8'(i - 1) || o_sel8 !== 3'(i - 1) || o_err8 !== 1'b0) begin
          n_fail++; $display("FAIL explicit_%0d got v=%b x=%0d sel=%0d err=%b want v=1 x=%0d sel=%0d err=0",
                             i - 1, o_valid8, o_x8, o_sel8, o_err8, i - 1, i - 1);
        end
      end
      valid8 = (i < 8); sel8 = 3'(i);
    end
    @(negedge clk);
    n_checks++; if (o_valid8 !== 1'b0) begin n_fail++; $display("FAIL explicit_drain got %b want 0", o_valid8); end
  endtask

  task automatic test_backpressure();
    x8 = ident8(); mode8 = 1'b0; ready8 = 1'b0; valid8 = 1'b1; sel8 = 3'd1;
    @(negedge clk);
    n_checks++; if (o_valid8 !== 1'b1 || o_x8 !== 4'd1 || o_ready8 !== 1'b1) begin
      n_fail++; $display("FAIL bp_a got v=%b x=%0d rdy=%b want v=1 x=1 rdy=1", o_valid8, o_x8, o_ready8); end
    sel8 = 3'd2;
    @(negedge clk);
    n_checks++; if (o_ready8 !== 1'b0 || o_x8 !== 4'd1) begin
      n_fail++; $display("FAIL bp_full got rdy=%b x=%0d want rdy=0 x=1", o_ready8, o_x8); end
    sel8 = 3'd5;
    @(negedge clk);
    n_checks++; if (o_ready8 !== 1'b0 || o_x8 !== 4'd1 || o_valid8 !== 1'b1) begin
      n_fail++; $display("FAIL bp_hold got rdy=%b x=%0d v=%b want rdy=0 x=1 v=1", o_ready8, o_x8, o_valid8); end
    valid8 = 1'b0; ready8 = 1'b1;
    @(negedge clk);
    n_checks++; if (o_valid8 !== 1'b1 || o_x8 !== 4'd2 || o_ready8 !== 1'b1) begin
      n_fail++; $display("FAIL bp_b got v=%b x=%0d rdy=%b want v=1 x=2 rdy=1", o_valid8, o_x8, o_ready8); end
    @(negedge clk);
    n_checks++; if (o_valid8 !== 1'b0) begin n_fail++; $display("FAIL bp_nodup got v=%b x=%0d want v=0", o_valid8, o_x8); end
  endtask

  task automatic test_scan();
    int exp_sel;
    x8 = ident8(); ready8 = 1'b1; mode8 = 1'b1; valid8 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      exp_sel = i % N8;
      n_checks++;
      if (o_valid8 !== 1'b1 || o_sel8 !== 3'(exp_sel) || o_x8 !== W8'(exp_sel) || o_err8 !== 1'b0) begin
        n_fail++; $display("FAIL scan_%0d got v=%b sel=%0d x=%0d err=%b want sel=%0d x=%0d",
                           i, o_valid8, o_sel8, o_x8, o_err8, exp_sel, exp_sel);
      end
      if (i == 9) begin mode8 = 1'b0; sel8 = 3'd5; end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++; if (o_sel8 !== 3'd5) begin n_fail++; $display("FAIL scan_explicit got %0d want 5", o_sel8); end
    end
    mode8 = 1'b1;
    @(negedge clk);
    n_checks++; if (o_sel8 !== 3'd2 || o_x8 !== 4'd2) begin
      n_fail++; $display("FAIL scan_resume got sel=%0d x=%0d want 2", o_sel8, o_x8); end
    valid8 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sel_err();
    for (int k = 0; k < N5; k++) x5[k*W5 +: W5] = W5'(k + 10);
    valid5 = 1'b1; sel5 = 3'd6;
    @(negedge clk);
    n_checks++; if (o_valid5 !== 1'b1 || o_x5 !== 4'd0 || o_sel5 !== 3'd6 || o_err5 !== 1'b1) begin
      n_fail++; $display("FAIL selerr_oor got v=%b x=%0d sel=%0d err=%b want v=1 x=0 sel=6 err=1",
                         o_valid5, o_x5, o_sel5, o_err5); end
    sel5 = 3'd4;
    @(negedge clk);
    n_checks++; if (o_x5 !== 4'd14 || o_sel5 !== 3'd4 || o_err5 !== 1'b0) begin
      n_fail++; $display("FAIL selerr_edge got x=%0d sel=%0d err=%b want x=14 sel=4 err=0", o_x5, o_sel5, o_err5); end
    valid5 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      x8     = {$urandom, $urandom};
      sel8   = 3'($urandom_range(0, 7));
      mode8  = 1'($urandom_range(0, 1));
      valid8 = ($urandom_range(0, 3) != 0);
      ready8 = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      n_checks++;
      if (o_valid8 !== (q.size() > 0) || o_ready8 !== (q.size() < 2)) begin
        n_fail++; $display("FAIL rand_hs cyc %0d got v=%b rdy=%b want v=%b rdy=%b",
                           c, o_valid8, o_ready8, q.size() > 0, q.size() < 2);
      end else if (q.size() > 0) begin
        if (o_x8 !== q[0].x || o_sel8 !== q[0].sel || o_err8 !== q[0].err) begin
          n_fail++; $display("FAIL rand_beat cyc %0d got x=%0h sel=%0d err=%b want x=%0h sel=%0d err=%b",
                             c, o_x8, o_sel8, o_err8, q[0].x, q[0].sel, q[0].err);
        end
      end
    end
    idle8();
  endtask

  task automatic test_reset_midop();
    x8 = ident8(); ready8 = 1'b0; mode8 = 1'b1; valid8 = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (o_ready8 !== 1'b0 || o_valid8 !== 1'b1) begin
      n_fail++; $display("FAIL midop_full got rdy=%b v=%b want rdy=0 v=1", o_ready8, o_valid8); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; valid8 = 1'b0; ready8 = 1'b1;
    #1;
    n_checks++; if (o_valid8 !== 1'b0 || o_ready8 !== 1'b1) begin
      n_fail++; $display("FAIL midop_release got v=%b rdy=%b want v=0 rdy=1", o_valid8, o_ready8); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++; if (o_valid8 !== 1'b0) begin n_fail++; $display("FAIL midop_stale got v=%b x=%0d want v=0", o_valid8, o_x8); end
    end
    valid8 = 1'b1;
    @(negedge clk);
    valid8 = 1'b0;
    n_checks++; if (o_valid8 !== 1'b1 || o_sel8 !== 3'd0) begin
      n_fail++; $display("FAIL midop_cnt got v=%b sel=%0d want v=1 sel=0", o_valid8, o_sel8); end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_explicit();
    test_backpressure();
    test_scan();
    test_sel_err();
    test_random();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
